store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter: DEPTH, 4, number of posted-store entries (power of two, 2..16).
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cpu_req  in  1  MEM-stage access valid this cycle.
REQ-005 cpu_we  in  1  1 = store (sw), 0 = load (lw).
REQ-006 cpu_addr  in  32  byte address; bits [1:0] ignored (word access).
REQ-007 cpu_wdata  in  32  store data.
REQ-008 cpu_rdata  out  32  load data to MEM/WB register.
REQ-009 cpu_stall  out  1  freeze F/D/E/M pipeline registers this cycle.
REQ-010 mem_req  out  1  memory request valid.
REQ-011 mem_we  out  1  memory request is a write.
REQ-012 mem_addr  out  32  memory word address, bits [1:0] = 0.
REQ-013 mem_wdata  out  32  memory write data.
REQ-014 mem_ack  in  1  one-cycle pulse: request completed.
REQ-015 mem_rdata  in  32  read data, valid in the mem_ack cycle.
REQ-016 sb_empty  out  1  no buffered stores and port idle.

Function
REQ-017 Buffer SHALL be a circular FIFO of DEPTH {addr[31:2], data} entries with head/tail pointers wrapping modulo DEPTH and a count 0..DEPTH.
REQ-018 Store, count < DEPTH: enqueue at tail on the same edge, cpu_stall = 0.
REQ-019 Store, count == DEPTH: cpu_stall = 1; enqueue on the first edge where count < DEPTH at cycle start; a drain ack in the same cycle does not clear the stall (stall depends only on registered state).
REQ-020 Simultaneous enqueue and drain-ack: count unchanged, both pointers advance.
REQ-021 Load hit (addr[31:2] matches any valid entry): cpu_rdata = data of youngest matching entry, combinationally, cpu_stall = 0.
REQ-022 Load miss: cpu_stall = 1 until data returned; no reordering hazard since no entry aliases.
REQ-023 Port FSM states: IDLE, WR (head write outstanding), RD (load read outstanding), RDONE.
REQ-024 IDLE -> RD when load miss pending (priority over draining); IDLE -> WR when count > 0 and no load miss.
REQ-025 WR -> IDLE on mem_ack, head pops; load miss arriving during WR waits for ack.
REQ-026 RD -> RDONE on mem_ack, mem_rdata captured into rdata register.
REQ-027 RDONE: cpu_stall = 0, cpu_rdata = captured value for exactly one cycle; -> IDLE.
REQ-028 mem_req, mem_we, mem_addr, mem_wdata SHALL be registered and held stable from request until and including the ack cycle; mem_req deasserts the cycle after ack; back-to-back requests have at least one idle cycle.
REQ-029 mem_ack outside WR/RD SHALL be ignored.
REQ-030 Load hit latency 0 cycles; load miss stall = memory latency + 2 cycles minimum.
REQ-031 cpu_req = 0: no enqueue, no stall, draining continues.
REQ-032 sb_empty = (count == 0) and state == IDLE.

Reset
REQ-033 On rst: count, head, tail = 0; state = IDLE; all entries invalid; rdata register = 0.
REQ-034 During rst: cpu_stall, mem_req, mem_we, sb_empty-inverted outputs = 0; cpu_rdata, mem_addr, mem_wdata = 0; sb_empty = 1.
REQ-035 rst mid-transaction SHALL discard buffered stores and any outstanding request; a late mem_ack after reset is ignored.

Structure
REQ-036 Shared package holds FSM state encoding (2-bit IDLE=00, WR=01, RD=10, RDONE=11) and DEPTH default.
REQ-037 One sub-module: sb_fifo (storage, pointers, count, youngest-match search); FSM and port logic in store_buffer.

Verification
REQ-038 Store 0x10<-0xAAAA0001, then load 0x10 next cycle -> cpu_rdata = 0xAAAA0001, cpu_stall = 0, no mem read issued.
REQ-039 Stores 0x20<-1 then 0x20<-2, load 0x20 before drain -> cpu_rdata = 2 (youngest).
REQ-040 Five back-to-back stores, mem_ack latency 3 -> fifth store stalls until first drain completes; memory sees writes in order 0x00..0x10.
REQ-041 Load miss 0x40, memory returns 0xDEADBEEF after 2 cycles -> stall asserted 4 cycles, then cpu_rdata = 0xDEADBEEF for one cycle.
REQ-042 Load miss while head write outstanding -> read issued only after write ack; mem_addr stable throughout each request.
REQ-043 Assert rst with 3 entries buffered and WR outstanding -> sb_empty = 1, mem_req = 0 next cycle, subsequent ack ignored, no further writes.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and constants for the posted-store buffer: port FSM encoding,
// bus widths and the default buffer depth.
package store_buffer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WR    = 2'b01,
    ST_RD    = 2'b10,
    ST_RDONE = 2'b11
  } port_state_t;

  localparam int SB_DEPTH_DEFAULT = 4;
  localparam int ADDR_W           = 32;
  localparam int DATA_W           = 32;
  localparam int WADDR_W          = ADDR_W - 2;

  function automatic logic [ADDR_W-1:0] byte_addr(input logic [WADDR_W-1:0] waddr);
    return {waddr, 2'b00};
  endfunction

endpackage

// File: rtl/store_buffer_if.sv
// CPU-side and memory-side signals of the store buffer. The slave modport is
// the buffer's view; master is the view of the CPU/memory environment.
interface store_buffer_if;
  import store_buffer_pkg::*;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              sb_empty;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    output cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, sb_empty
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_ack, mem_rdata,
    input  cpu_rdata, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata, sb_empty
  );

endinterface

// File: rtl/store_buffer_sb_fifo.sv
// Circular store FIFO: word address + data per entry, head/tail/count control,
// and a combinational youngest-match lookup for load forwarding.
module sb_fifo
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [WADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0]  push_data,
  input  logic               pop,
  input  logic [WADDR_W-1:0] lookup_addr,
  output logic               hit,
  output logic [DATA_W-1:0]  hit_data,
  output logic [WADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0]  head_data,
  output logic               full,
  output logic               empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   head_q, head_d, tail_q, tail_d, idx;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [WADDR_W-1:0] addr_q [DEPTH];
  logic [WADDR_W-1:0] addr_d [DEPTH];
  logic [DATA_W-1:0]  data_q [DEPTH];
  logic [DATA_W-1:0]  data_d [DEPTH];
  logic               do_push, do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_push   = push & ~full;
  assign do_pop    = pop & ~empty;
  assign head_addr = addr_q[head_q];
  assign head_data = data_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (do_push) begin
      addr_d[tail_q]  = push_addr;
      data_d[tail_q]  = push_data;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (do_pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PTR_W'(i);
      if (valid_q[idx] && (addr_q[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-store buffer between the MEM stage and a single-port memory: stores
// are buffered and drained in order, loads forward from the buffer or stall.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  store_buffer_if.slave bus
);

  port_state_t        state_q, state_d;
  logic               mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d, rdata_q, rdata_d;
  logic [ADDR_W-1:0]  cpu_word_addr;
  logic               is_store, is_load, hit, full, empty, push, pop, load_miss;
  logic [DATA_W-1:0]  hit_data, head_data;
  logic [WADDR_W-1:0] head_addr;

  assign cpu_word_addr = bus.cpu_addr & ~ADDR_W'(3);
  assign is_store      = bus.cpu_req & bus.cpu_we;
  assign is_load       = bus.cpu_req & ~bus.cpu_we;
  assign push          = is_store & ~full;
  assign pop           = (state_q == ST_WR) & bus.mem_ack;
  // In RDONE the frozen load is satisfied from the captured read data.
  assign load_miss     = is_load & ~hit & (state_q != ST_RDONE);

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (cpu_word_addr[ADDR_W-1:2]),
    .push_data  (bus.cpu_wdata),
    .pop        (pop),
    .lookup_addr(cpu_word_addr[ADDR_W-1:2]),
    .hit        (hit),
    .hit_data   (hit_data),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .full       (full),
    .empty      (empty)
  );

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    case (state_q)
      ST_IDLE: begin
        if (load_miss) begin
          state_d    = ST_RD;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = cpu_word_addr;
        end else if (!empty) begin
          state_d     = ST_WR;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b1;
          mem_addr_d  = byte_addr(head_addr);
          mem_wdata_d = head_data;
        end
      end
      ST_WR: begin
        if (bus.mem_ack) begin
          state_d   = ST_IDLE;
          mem_req_d = 1'b0;
        end
      end
      ST_RD: begin
        if (bus.mem_ack) begin
          state_d   = ST_RDONE;
          mem_req_d = 1'b0;
          rdata_d   = bus.mem_rdata;
        end
      end
      ST_RDONE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.cpu_stall = ~rst & ((is_store & full) | load_miss);
  assign bus.cpu_rdata = (state_q == ST_RDONE) ? rdata_q : (hit ? hit_data : '0);
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.sb_empty  = empty & (state_q == ST_IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: forwarding, full stall, load miss timing,
// read behind an outstanding write, and reset mid-transaction.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        resp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  logic [31:0] resp_rdata = '0;
  logic [31:0] rd_value = '0;
  int          lat = 3;
  int          nchecks = 0;
  int          nerrors = 0;
  int          r_age = 0;
  logic [31:0] r_addr, r_wdata;
  logic        r_we;
  logic [64:0] log_q[$];
  logic [64:0] exp_q[$];
  int          n;

  store_buffer_if bus();

  assign bus.mem_ack   = resp_ack | stray_ack;
  assign bus.mem_rdata = resp_rdata;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    nchecks++;
    assert (obs === exp) else begin
      nerrors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic drive(input logic req, input logic we, input logic [31:0] a, input logic [31:0] d);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_addr  = a;
    bus.cpu_wdata = d;
  endtask

  task automatic wait_empty(input int max);
    int k;
    k = 0;
    while (!bus.sb_empty && k < max) begin
      step();
      drive(1'b0, 1'b0, 32'h0, 32'h0);
      look();
      k++;
    end
    chk("drain_done", bus.sb_empty, 1'b1);
  endtask

  // Memory model: acks after lat cycles of mem_req, logs each completed access.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      resp_ack   = 1'b0;
      resp_rdata = '0;
      if (!bus.mem_req || rst) begin
        r_age = 0;
      end else begin
        if (r_age == 0) begin
          r_addr  = bus.mem_addr;
          r_wdata = bus.mem_wdata;
          r_we    = bus.mem_we;
        end else begin
          chk("mem_hold", {bus.mem_we, bus.mem_addr, bus.mem_wdata}, {r_we, r_addr, r_wdata});
        end
        if (r_age == lat) begin
          resp_ack = 1'b1;
          if (!r_we) resp_rdata = rd_value;
          log_q.push_back({r_we, r_addr, r_we ? r_wdata : 32'h0});
          r_age = 0;
        end else begin
          r_age++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h40, 32'h0);
    step();
    look();
    chk("rst_stall", bus.cpu_stall, 1'b0);
    chk("rst_mem_req", bus.mem_req, 1'b0);
    chk("rst_mem_we", bus.mem_we, 1'b0);
    chk("rst_empty", bus.sb_empty, 1'b1);
    chk("rst_rdata", bus.cpu_rdata, 32'h0);
    chk("rst_mem_addr", bus.mem_addr, 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    step();
    rst = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    look();
    chk("post_rst_empty", bus.sb_empty, 1'b1);

    // Store then forward to the next-cycle load.
    lat = 3;
    step(); drive(1'b1, 1'b1, 32'h10, 32'hAAAA0001); look();
    chk("t1_store_stall", bus.cpu_stall, 1'b0);
    step(); drive(1'b1, 1'b0, 32'h10, 32'h0); look();
    chk("t1_fwd_rdata", bus.cpu_rdata, 32'hAAAA0001);
    chk("t1_fwd_stall", bus.cpu_stall, 1'b0);
    chk("t1_no_read", bus.mem_req, 1'b0);
    chk("t1_not_empty", bus.sb_empty, 1'b0);
    step(); drive(1'b0, 1'b0, 32'h0, 32'h0); look();
    chk("t1_drain_req", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b11, 32'h10});
    wait_empty(20);
    exp_q.push_back({1'b1, 32'h10, 32'hAAAA0001});

    // Youngest match wins; low address bits ignored.
    step(); drive(1'b1, 1'b1, 32'h20, 32'h1); look();
    step(); drive(1'b1, 1'b1, 32'h20, 32'h2); look();
    step(); drive(1'b1, 1'b0, 32'h23, 32'h0); look();
    chk("t2_youngest", bus.cpu_rdata, 32'h2);
    chk("t2_stall", bus.cpu_stall, 1'b0);
    wait_empty(30);
    exp_q.push_back({1'b1, 32'h20, 32'h1});
    exp_q.push_back({1'b1, 32'h20, 32'h2});

    // Five back-to-back stores into a 4-deep buffer.
    for (int i = 0; i < 4; i++) begin
      step(); drive(1'b1, 1'b1, 32'(i * 4), 32'h100 + 32'(i)); look();
      chk("t3_store_nostall", bus.cpu_stall, 1'b0);
    end
    step(); drive(1'b1, 1'b1, 32'h10, 32'h104); look();
    chk("t3_full_stall", bus.cpu_stall, 1'b1);
    step(); look();
    chk("t3_stall_in_ack", {bus.cpu_stall, bus.mem_req}, 2'b11);
    step(); look();
    chk("t3_enq_after_drain", bus.cpu_stall, 1'b0);
    wait_empty(60);
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b1, 32'(i * 4), 32'h100 + 32'(i)});

    // Load miss, memory latency 2.
    lat = 2;
    rd_value = 32'hDEADBEEF;
    step(); drive(1'b1, 1'b0, 32'h40, 32'h0); look();
    chk("t4_stall_c0", bus.cpu_stall, 1'b1);
    for (int k = 1; k < 4; k++) begin
      step(); look();
      chk("t4_stall", bus.cpu_stall, 1'b1);
      if (k == 1) chk("t4_read_req", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b10, 32'h40});
    end
    step(); look();
    chk("t4_release", bus.cpu_stall, 1'b0);
    chk("t4_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    step(); drive(1'b0, 1'b0, 32'h0, 32'h0); look();
    chk("t4_rdata_one_cycle", bus.cpu_rdata, 32'h0);
    chk("t4_empty", bus.sb_empty, 1'b1);
    exp_q.push_back({1'b0, 32'h40, 32'h0});

    // Load miss arrives while the head write is outstanding.
    lat = 3;
    rd_value = 32'h12345678;
    step(); drive(1'b1, 1'b1, 32'h80, 32'h55); look();
    chk("t5_store", bus.cpu_stall, 1'b0);
    step(); drive(1'b0, 1'b0, 32'h0, 32'h0); look();
    step(); drive(1'b1, 1'b0, 32'h90, 32'h0); look();
    for (int k = 2; k < 6; k++) begin
      chk("t5_stall_wr", bus.cpu_stall, 1'b1);
      chk("t5_wr_req", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b11, 32'h80});
      step(); look();
    end
    chk("t5_gap_stall", bus.cpu_stall, 1'b1);
    chk("t5_gap", bus.mem_req, 1'b0);
    step(); look();
    chk("t5_rd_req", {bus.mem_req, bus.mem_we, bus.mem_addr}, {2'b10, 32'h90});
    for (int k = 7; k < 11; k++) begin
      chk("t5_stall_rd", bus.cpu_stall, 1'b1);
      step(); look();
    end
    chk("t5_release", bus.cpu_stall, 1'b0);
    chk("t5_rdata", bus.cpu_rdata, 32'h12345678);
    step(); drive(1'b0, 1'b0, 32'h0, 32'h0); look();
    wait_empty(20);
    exp_q.push_back({1'b1, 32'h80, 32'h55});
    exp_q.push_back({1'b0, 32'h90, 32'h0});

    // Reset with three entries buffered and a write outstanding.
    lat = 5;
    step(); drive(1'b1, 1'b1, 32'hA0, 32'hA0A0); look();
    step(); drive(1'b1, 1'b1, 32'hA4, 32'hA4A4); look();
    step(); drive(1'b1, 1'b1, 32'hA8, 32'hA8A8); look();
    chk("t6_wr_outstanding", {bus.mem_req, bus.mem_we}, 2'b11);
    step(); drive(1'b0, 1'b0, 32'h0, 32'h0); rst = 1'b1; look();
    chk("t6_rst_empty", bus.sb_empty, 1'b1);
    chk("t6_rst_stall", bus.cpu_stall, 1'b0);
    step(); rst = 1'b0; look();
    chk("t6_req_after_rst", {bus.mem_req, bus.sb_empty}, 2'b01);
    step(); stray_ack = 1'b1; look();
    chk("t6_stray_ack", {bus.mem_req, bus.sb_empty}, 2'b01);
    step(); stray_ack = 1'b0; look();
    for (int k = 0; k < 8; k++) begin
      chk("t6_no_writes", {bus.mem_req, bus.sb_empty}, 2'b01);
      step(); look();
    end
    lat = 1;
    rd_value = 32'h0BADF00D;
    step(); drive(1'b1, 1'b0, 32'hA0, 32'h0); look();
    chk("t6_discarded", bus.cpu_stall, 1'b1);
    n = 0;
    while (bus.cpu_stall && n < 20) begin
      step(); look();
      n++;
    end
    chk("t6_miss_latency", n, 3);
    chk("t6_rdata", bus.cpu_rdata, 32'h0BADF00D);
    step(); drive(1'b0, 1'b0, 32'h0, 32'h0); look();
    exp_q.push_back({1'b0, 32'hA0, 32'h0});

    chk("log_len", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("log_%0d", i), log_q[i], exp_q[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
